timer_entry: RTL

//  Keypad-side writer for the countdown timer chain: collects BCD digits typed by the user

---
 rtl/timer_entry.sv | 127 ++++++++++++
 1 files changed

// File: rtl/timer_entry.sv
// Keypad entry writer for the MM:SS countdown chain: collects BCD digits, validates them,
// then strobes them into the counters (loadn low for LOAD_PULSE_CYCLES) and pulses start.
module timer_entry #(
  parameter int NUM_DIGITS        = 4,
  parameter int SEC_TENS_MAX      = 5,
  parameter int LOAD_PULSE_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      key_valid_i,
  input  logic [3:0]                key_code_i,
  input  logic                      done_i,
  output logic [4*NUM_DIGITS-1:0]   load_data_o,
  output logic                      loadn_o,
  output logic                      start_o,
  output logic                      abort_o,
  output logic                      err_o,
  output logic                      key_ready_o,
  output logic                      busy_o
);

  localparam int DW  = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam int LCW = (LOAD_PULSE_CYCLES > 1) ? $clog2(LOAD_PULSE_CYCLES) : 1;

  localparam logic [CW-1:0]  CNT_FULL     = CW'(NUM_DIGITS);
  localparam logic [LCW-1:0] LOAD_LAST    = LCW'(LOAD_PULSE_CYCLES - 1);
  localparam logic [3:0]     SEC_TENS_LIM = 4'(SEC_TENS_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  digits_q;
  logic [CW-1:0]  cnt_q;
  logic [LCW-1:0] load_cnt_q;
  logic           loadn_q;
  logic           start_q;
  logic           abort_q;
  logic           err_q;

  logic is_digit;
  logic is_clear;
  logic is_start;
  logic entry_ok;

  assign is_digit = key_valid_i && (key_code_i <= 4'd9);
  assign is_clear = key_valid_i && (key_code_i == 4'hA);
  assign is_start = key_valid_i && (key_code_i == 4'hB);

  // Digits are BCD by construction, so only the seconds-tens limit and all-zero need checking.
  assign entry_ok = (digits_q[7:4] <= SEC_TENS_LIM) && (digits_q != '0);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      cnt_q      <= '0;
      load_cnt_q <= '0;
      loadn_q    <= 1'b1;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (is_digit) begin
            if (cnt_q < CNT_FULL) begin
              digits_q <= {digits_q[DW-5:0], key_code_i};
              cnt_q    <= cnt_q + 1'b1;
              state_q  <= S_ENTRY;
            end else begin
              err_q <= 1'b1;
            end
          end else if (is_clear) begin
            digits_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else if (is_start) begin
            if ((state_q == S_ENTRY) && entry_ok) begin
              state_q    <= S_LOAD;
              loadn_q    <= 1'b0;
              load_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (load_cnt_q == LOAD_LAST) begin
            loadn_q <= 1'b1;
            start_q <= 1'b1;
            state_q <= S_RUN;
          end else begin
            load_cnt_q <= load_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          // CLEAR and done land in the same place; only CLEAR reports an abort.
          if (is_clear || done_i) begin
            abort_q  <= is_clear;
            digits_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_data_o = digits_q;
  assign loadn_o     = loadn_q;
  assign start_o     = start_q;
  assign abort_o     = abort_q;
  assign err_o       = err_q;
  assign key_ready_o = (state_q == S_IDLE) || (state_q == S_ENTRY);
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN);

endmodule
